// File: rtl/imm_pkg.sv
// Shared constants for the immediate decode pipeline: format codes,
// base-ISA opcode values and the XLEN-dependent shift-amount width.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'b000,
        FMT_I     = 3'b001,
        FMT_S     = 3'b010,
        FMT_B     = 3'b011,
        FMT_U     = 3'b100,
        FMT_J     = 3'b101,
        FMT_SHAMT = 3'b110
    } fmt_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;

    // RV64 shifts take a 6-bit amount, RV32 a 5-bit one.
    function automatic int shamt_width(input int xlen);
        return (xlen == 64) ? 6 : 5;
    endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Generic two-entry valid/ready skid buffer. The main register drives the
// output; the skid entry catches one extra item when the consumer stalls.
// in_ready comes straight from a flop so no combinational path exists from
// out_ready back to the producer.
module imm_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              main_vld_p1;
    logic [DATA_W-1:0] main_data_p1;
    logic              skid_vld_p1;
    logic [DATA_W-1:0] skid_data_p1;
    logic              ready_p1;

    // Main/skid entry update: refill from skid first, park in skid when the
    // main entry is stalled, otherwise load (or empty) the main entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_vld_p1  <= 1'b0;
            main_data_p1 <= '0;
            skid_vld_p1  <= 1'b0;
            skid_data_p1 <= '0;
            ready_p1     <= 1'b1;
        end else if (skid_vld_p1) begin
            // Producer is blocked here; only a drain can make progress.
            if (out_ready) begin
                main_data_p1 <= skid_data_p1;
                skid_vld_p1  <= 1'b0;
                ready_p1     <= 1'b1;
            end
        end else if (main_vld_p1 && !out_ready) begin
            // Main entry stalled: an accepted item goes to the skid entry.
            if (in_valid) begin
                skid_data_p1 <= in_data;
                skid_vld_p1  <= 1'b1;
                ready_p1     <= 1'b0;
            end
        end else begin
            // Main entry empty or draining this cycle: overwrite or empty it.
            main_vld_p1 <= in_valid;
            if (in_valid) begin
                main_data_p1 <= in_data;
            end
        end
    end

    assign in_ready  = ready_p1;
    assign out_valid = main_vld_p1;
    assign out_data  = main_data_p1;

endmodule

// File: rtl/imm_decode_pipe.sv
// Immediate decode stage: classifies the instruction's immediate format,
// assembles and extends the immediate to XLEN, flags unknown opcodes and
// out-of-range RV32 shift amounts, and registers the result behind a
// two-entry skid buffer.
module imm_decode_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PAYLOAD_W = XLEN + 3 + 1 + TAG_W;
    localparam int SHAMT_W   = shamt_width(XLEN);

    // ---- p0: combinational decode of the incoming word ----
    logic [6:0]        opcode_p0;
    logic [2:0]        funct3_p0;
    logic signed [11:0] imm_i_p0;
    logic signed [11:0] imm_s_p0;
    logic signed [12:0] imm_b_p0;
    logic signed [31:0] imm_u_p0;
    logic signed [20:0] imm_j_p0;
    logic [XLEN-1:0]   imm_p0;
    fmt_e              fmt_p0;
    logic              illegal_p0;
    logic [PAYLOAD_W-1:0] payload_p0;

    assign opcode_p0 = in_instr[6:0];
    assign funct3_p0 = in_instr[14:12];

    // Raw immediate fields; all signed so the XLEN casts below sign-extend.
    assign imm_i_p0 = in_instr[31:20];
    assign imm_s_p0 = {in_instr[31:25], in_instr[11:7]};
    assign imm_b_p0 = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u_p0 = {in_instr[31:12], 12'b0};
    assign imm_j_p0 = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // Format selection and extension to XLEN.
    always_comb begin
        fmt_p0     = FMT_NONE;
        imm_p0     = '0;
        illegal_p0 = 1'b0;
        case (opcode_p0)
            OPC_LUI, OPC_AUIPC: begin
                fmt_p0 = FMT_U;
                imm_p0 = XLEN'(imm_u_p0);
            end
            OPC_JAL: begin
                fmt_p0 = FMT_J;
                imm_p0 = XLEN'(imm_j_p0);
            end
            OPC_JALR, OPC_LOAD, OPC_MISC_MEM, OPC_SYSTEM: begin
                fmt_p0 = FMT_I;
                imm_p0 = XLEN'(imm_i_p0);
            end
            OPC_OP_IMM: begin
                if (funct3_p0 == 3'b001 || funct3_p0 == 3'b101) begin
                    // Shift amounts are unsigned; on RV32 bit 25 must be clear.
                    fmt_p0 = FMT_SHAMT;
                    if (SHAMT_W == 6) begin
                        imm_p0 = XLEN'(in_instr[25:20]);
                    end else begin
                        imm_p0     = XLEN'(in_instr[24:20]);
                        illegal_p0 = in_instr[25];
                    end
                end else begin
                    fmt_p0 = FMT_I;
                    imm_p0 = XLEN'(imm_i_p0);
                end
            end
            OPC_STORE: begin
                fmt_p0 = FMT_S;
                imm_p0 = XLEN'(imm_s_p0);
            end
            OPC_BRANCH: begin
                fmt_p0 = FMT_B;
                imm_p0 = XLEN'(imm_b_p0);
            end
            OPC_OP: begin
                fmt_p0 = FMT_NONE;
            end
            default: begin
                illegal_p0 = 1'b1;
            end
        endcase
    end

    assign payload_p0 = {imm_p0, fmt_p0, illegal_p0, in_tag};

    // ---- p1: registered output stage with skid entry ----
    logic [PAYLOAD_W-1:0] payload_p1;

    imm_skid_buf #(
        .DATA_W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (payload_p0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (payload_p1)
    );

    assign {out_imm, out_fmt, out_illegal, out_tag} = payload_p1;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Scoreboard bench for imm_decode_pipe: one RV32 and one RV64 instance,
// expected results queued as stimulus is accepted and compared on output.
module tb_imm_decode_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // RV32 instance signals
    logic        in_valid32 = 1'b0;
    logic        in_ready32;
    logic [31:0] in_instr32 = '0;
    logic [31:0] in_tag32 = '0;
    logic        out_valid32;
    logic        out_ready32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic        out_illegal32;
    logic [31:0] out_tag32;

    // RV64 instance signals
    logic        in_valid64 = 1'b0;
    logic        in_ready64;
    logic [31:0] in_instr64 = '0;
    logic [31:0] in_tag64 = '0;
    logic        out_valid64;
    logic        out_ready64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic        out_illegal64;
    logic [31:0] out_tag64;

    logic rdy32_cmd = 1'b1;
    logic rdy64_cmd = 1'b1;
    logic rand_mode = 1'b0;
    logic rnd32 = 1'b1;
    logic rnd64 = 1'b1;

    assign out_ready32 = rand_mode ? rnd32 : rdy32_cmd;
    assign out_ready64 = rand_mode ? rnd64 : rdy64_cmd;

    always @(negedge clk) begin
        rnd32 = ($urandom_range(0, 3) != 0);
        rnd64 = ($urandom_range(0, 3) != 0);
    end

    imm_decode_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .in_instr(in_instr32), .in_tag(in_tag32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .out_imm(out_imm32), .out_fmt(out_fmt32),
        .out_illegal(out_illegal32), .out_tag(out_tag32)
    );

    imm_decode_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .in_instr(in_instr64), .in_tag(in_tag64),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .out_imm(out_imm64), .out_fmt(out_fmt64),
        .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    int checks = 0;
    int failures = 0;
    exp_t q32[$];
    exp_t q64[$];

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference decode, written with 64-bit signed arithmetic and truncated
    // to 32 bits for the RV32 instance.
    function automatic exp_t model(input logic [31:0] w, input bit is64, input logic [31:0] tag);
        exp_t e;
        longint v;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        e.tag = tag;
        v = 0;
        case (w[6:0])
            7'h37, 7'h17: begin e.fmt = 3'd4; v = longint'($signed({w[31:12], 12'h000})); end
            7'h6F: begin e.fmt = 3'd5; v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
            7'h67, 7'h03, 7'h0F, 7'h73: begin e.fmt = 3'd1; v = longint'($signed(w[31:20])); end
            7'h13: begin
                if (w[13:12] == 2'b01) begin
                    e.fmt = 3'd6;
                    if (is64) v = longint'({58'd0, w[25:20]});
                    else begin v = longint'({59'd0, w[24:20]}); e.ill = w[25]; end
                end else begin
                    e.fmt = 3'd1;
                    v = longint'($signed(w[31:20]));
                end
            end
            7'h23: begin e.fmt = 3'd2; v = longint'($signed({w[31:25], w[11:7]})); end
            7'h63: begin e.fmt = 3'd3; v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
            7'h33: begin e.fmt = 3'd0; end
            default: begin e.ill = 1'b1; end
        endcase
        e.imm = is64 ? 64'(v) : {32'h0, v[31:0]};
        return e;
    endfunction

    function automatic exp_t mk(input logic [63:0] imm, input logic [2:0] fmt,
                                input logic ill, input logic [31:0] tag);
        exp_t e;
        e.imm = imm; e.fmt = fmt; e.ill = ill; e.tag = tag;
        return e;
    endfunction

    // Drive one instruction (called at a negedge); returns at the negedge
    // after the accepting edge.
    task automatic push(input bit is64, input logic [31:0] instr, input logic [31:0] tag, input exp_t e);
        int n;
        n = 0;
        if (is64) begin
            in_valid64 = 1'b1; in_instr64 = instr; in_tag64 = tag;
            while (!in_ready64 && n < 200) begin @(negedge clk); n++; end
        end else begin
            in_valid32 = 1'b1; in_instr32 = instr; in_tag32 = tag;
            while (!in_ready32 && n < 200) begin @(negedge clk); n++; end
        end
        if (n >= 200) begin
            chk_eq("in_ready_timeout", 64'd0, 64'd1);
        end else begin
            if (is64) q64.push_back(e); else q32.push_back(e);
            @(negedge clk);
        end
        in_valid32 = 1'b0;
        in_valid64 = 1'b0;
    endtask

    // Output monitors: sample mid-low-phase, compare every transfer.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && out_valid32 && out_ready32) begin
            if (q32.size() == 0) begin
                chk_eq("unexpected_out32", {32'h0, out_tag32}, 64'hDEAD_0000);
            end else begin
                e = q32.pop_front();
                chk_eq("imm32", {32'h0, out_imm32}, e.imm);
                chk_eq("fmt32", {61'h0, out_fmt32}, {61'h0, e.fmt});
                chk_eq("ill32", {63'h0, out_illegal32}, {63'h0, e.ill});
                chk_eq("tag32", {32'h0, out_tag32}, {32'h0, e.tag});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && out_valid64 && out_ready64) begin
            if (q64.size() == 0) begin
                chk_eq("unexpected_out64", {32'h0, out_tag64}, 64'hDEAD_0000);
            end else begin
                e = q64.pop_front();
                chk_eq("imm64", out_imm64, e.imm);
                chk_eq("fmt64", {61'h0, out_fmt64}, {61'h0, e.fmt});
                chk_eq("ill64", {63'h0, out_illegal64}, {63'h0, e.ill});
                chk_eq("tag64", {32'h0, out_tag64}, {32'h0, e.tag});
            end
        end
    end

    logic [31:0] ops [11];

    initial begin
        ops = '{32'h37, 32'h17, 32'h6F, 32'h67, 32'h03, 32'h0F, 32'h73, 32'h13, 32'h23, 32'h63, 32'h33};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("rst_out_valid32", {63'h0, out_valid32}, 64'd0);
        chk_eq("rst_in_ready32", {63'h0, in_ready32}, 64'd1);
        chk_eq("rst_out_imm32", {32'h0, out_imm32}, 64'd0);
        chk_eq("rst_out_fmt32", {61'h0, out_fmt32}, 64'd0);
        chk_eq("rst_out_illegal32", {63'h0, out_illegal32}, 64'd0);
        chk_eq("rst_out_tag32", {32'h0, out_tag32}, 64'd0);
        chk_eq("rst_out_valid64", {63'h0, out_valid64}, 64'd0);
        chk_eq("rst_in_ready64", {63'h0, in_ready64}, 64'd1);
        chk_eq("rst_out_imm64", out_imm64, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // addi x1,x0,-1 with one-cycle latency
        push(0, 32'hFFF00093, 32'hA5A5_0001, mk(64'hFFFF_FFFF, 3'd1, 1'b0, 32'hA5A5_0001));
        chk_eq("latency_valid32", {63'h0, out_valid32}, 64'd1);
        @(negedge clk);

        // Back-to-back sw / jal / lui
        push(0, 32'hFE20AE23, 32'h10, mk(64'hFFFF_FFFC, 3'd2, 1'b0, 32'h10));
        push(0, 32'hFF9FF06F, 32'h11, mk(64'hFFFF_FFF8, 3'd5, 1'b0, 32'h11));
        push(0, 32'h123452B7, 32'h12, mk(64'h1234_5000, 3'd4, 1'b0, 32'h12));

        // RV64 U sign extension and 6-bit shamt; same shamt word on RV32
        push(1, 32'h800002B7, 32'h20, mk(64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, 32'h20));
        push(1, 32'h02109093, 32'h21, mk(64'd33, 3'd6, 1'b0, 32'h21));
        push(0, 32'h02109093, 32'h22, mk(64'd1, 3'd6, 1'b1, 32'h22));

        // Unknown opcode and register-register op
        push(0, 32'h0000007F, 32'h23, mk(64'd0, 3'd0, 1'b1, 32'h23));
        push(0, 32'h00208033, 32'h24, mk(64'd0, 3'd0, 1'b0, 32'h24));
        repeat (2) @(negedge clk);

        // Backpressure: fill main and skid, check hold, then drain in order
        rdy32_cmd = 1'b0;
        push(0, 32'hFFF00093, 32'd1, mk(64'hFFFF_FFFF, 3'd1, 1'b0, 32'd1));
        push(0, 32'h00500093, 32'd2, mk(64'd5, 3'd1, 1'b0, 32'd2));
        chk_eq("bp_in_ready_low", {63'h0, in_ready32}, 64'd0);
        repeat (3) @(negedge clk);
        chk_eq("bp_hold_valid", {63'h0, out_valid32}, 64'd1);
        chk_eq("bp_hold_tag", {32'h0, out_tag32}, 64'd1);
        chk_eq("bp_hold_imm", {32'h0, out_imm32}, 64'hFFFF_FFFF);
        rdy32_cmd = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk_eq("bp_drained", 64'(q32.size()), 64'd0);
        chk_eq("bp_in_ready_back", {63'h0, in_ready32}, 64'd1);
        @(negedge clk);

        // Reset with both entries full discards them
        rdy32_cmd = 1'b0;
        push(0, 32'h00100093, 32'd7, mk(64'd1, 3'd1, 1'b0, 32'd7));
        push(0, 32'h00200093, 32'd8, mk(64'd2, 3'd1, 1'b0, 32'd8));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q32.delete();
        chk_eq("rst_mid_out_valid", {63'h0, out_valid32}, 64'd0);
        chk_eq("rst_mid_in_ready", {63'h0, in_ready32}, 64'd1);
        rdy32_cmd = 1'b1;
        repeat (5) @(negedge clk);
        chk_eq("rst_mid_no_stale", {63'h0, out_valid32}, 64'd0);

        // Randomised stream with random consumer stalls on both widths
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] w;
            w = {$urandom()} ;
            if (i % 8 != 7) w[6:0] = ops[$urandom_range(0, 10)][6:0];
            push(i % 2, w, 32'(i + 100), model(w, i % 2, 32'(i + 100)));
        end
        begin
            int n;
            n = 0;
            while ((q32.size() != 0 || q64.size() != 0) && n < 500) begin
                @(negedge clk); n++;
            end
            #3;
            chk_eq("final_drain", 64'(q32.size() + q64.size()), 64'd0);
        end
        rand_mode = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
